exe_wb_scheduler: RTL and testbench
===================================

# exe_wb_scheduler

Parametrised writeback stage placed after the execute functional units. It buffers each FU's ROB/register writeback result in a per-FU queue and schedules up to NUM_CDB_P results per cycle onto multiple CDB/ROB/register write ports, so FUs no longer need a private, always-available broadcast slot. Per-FU backpressure feeds issue. The whole block flushes on branch misprediction.

## Interface
- NUM_FU_P, default NUM_FU: number of FU result streams.
- NUM_CDB_P, default 2: writeback ports per cycle; 1 ≤ NUM_CDB_P ≤ NUM_FU_P.
- Q_DEPTH_P, default 4: entries per FU queue; power of two, ≥ 2.
- clk_i  in  1  clock; single clock domain.
- reset_i  in  1  asynchronous, active-high reset.
- fu_v_i  in  NUM_FU_P  result valid per FU.
- fu_rob_i  in  NUM_FU_P × ROB_WB_WIDTH  ROB writeback payload per FU.
- fu_reg_i  in  NUM_FU_P × REG_WB_WIDTH  register writeback payload per FU.
- fu_ready_o  out  NUM_FU_P  queue can accept a result this cycle.
- cdb_v_o  out  NUM_CDB_P  port valid.
- cdb_o  out  NUM_CDB_P × CDB_WIDTH  top CDB_WIDTH bits of the granted ROB payload.
- exe_rob_o  out  NUM_CDB_P × ROB_WB_WIDTH  granted ROB payload.
- exe_reg_o  out  NUM_CDB_P × REG_WB_WIDTH  granted register payload.
- mispredict_i  in  1  flush request.
- rob_head_i  in  $clog2(ROB_ENTRY)  ROB head index. Present only with EXE_WB_AGE_PRIO_EN.

## Operation
- Each FU has its own FIFO of Q_DEPTH_P entries {rob, reg}. Occupancy count is $clog2(Q_DEPTH_P)+1 bits. Read and write pointers wrap modulo Q_DEPTH_P.
- fu_ready_o[i] = count_i < Q_DEPTH_P. The output is combinational from registered count. A pop in the same cycle does not free a slot.
- Push when fu_v_i[i] && fu_ready_o[i]. fu_v_i while not ready is a protocol violation: the result is dropped and a simulation assertion fires.
- Scheduling is round-robin by default:
  - Scan FUs starting at rr_ptr_q and pick the first NUM_CDB_P non-empty queues, at most one per FU per cycle.
  - The k-th pick drives port k.
  - Picked queues pop at the clock edge.
  - rr_ptr_q becomes (last picked FU + 1) mod NUM_FU_P. It is unchanged when nothing is picked.
- Output registers:
  - Port k loads the picked payload and sets cdb_v_o[k] = 1.
  - Unused ports get valid 0 and payload '0.
  - cdb_o[k] is always exe_rob_o[k][ROB_WB_WIDTH-1 -: CDB_WIDTH].
- Flush: when mispredict_i = 1 at an edge, all of the following happen:
  - All counts and pointers clear and rr_ptr_q returns to 0.
  - All output valids and payloads clear.
  - That cycle's fu_v_i pushes are discarded.
  - No grant is issued from that cycle.
- Simultaneous push and pop on the same queue is legal when not full; count stays unchanged.
- Reset (asynchronous, any time, including mid-flush or with full queues):
  - Queues empty, rr_ptr_q = 0.
  - All outputs 0; fu_ready_o all 1 after reset.

## Timing
- Result presented in cycle N (accepted) → earliest cdb_v_o in cycle N+2. Cycle N+1 is the grant; the registered output appears in N+2.
- Throughput: NUM_CDB_P results per cycle total; at most 1 per FU per cycle.
- Backpressure has no lag: fu_ready_o[i] drops in the cycle after the push that fills the queue.
- mispredict_i in cycle M → all cdb_v_o = 0 in M+1. New results accepted in M+1 appear no earlier than M+3.
- Each FU's results emerge in arrival order. Ordering across FUs is set by the scheduling policy only.

## Configuration
- EXE_WB_AGE_PRIO_EN defined:
  - The rob_head_i port exists.
  - Each non-empty head computes age = (rob_dest − rob_head_i) mod ROB_ENTRY, with rob_dest read from the payload's rob_dest field.
  - The NUM_CDB_P smallest ages are granted, ascending age on ascending port index. Ties go to the lower FU index.
  - rr_ptr_q is not implemented.
- EXE_WB_AGE_PRIO_EN undefined: round-robin as above, and there is no rob_head_i port.

## Structure
- Shared package:
  - NUM_CDB and WB_Q_DEPTH default constants.
  - typedef wb_entry_t {rob_wb, reg_wb}.
  - Function rob_age(tag, head) for the age-priority mode.
- Sub-module wb_result_fifo: single-FU queue with push, pop, full, empty and count, instantiated NUM_FU_P times in a generate loop.
- Top level holds the scheduler, rr_ptr_q, output registers and flush fan-out.

## Test plan
- Single result, defaults: fu_v_i[0] = 1 in cycle 1 with rob tag 5 → cdb_v_o[0] = 1 in cycle 3 carrying tag 5; cdb_v_o[1] = 0.
- All 6 FUs push together in cycle 1, NUM_CDB_P = 2, round-robin → grants are FU{0,1} in cycle 3, FU{2,3} in cycle 4, FU{4,5} in cycle 5; rr_ptr_q = 0 afterwards.
- FU2 pushes every cycle while other FUs also compete, Q_DEPTH_P = 4 → fu_ready_o[2] drops after 4 unpopped pushes; no loss; FIFO order preserved.
- Flush: 3 entries queued in each of FU0 and FU1, mispredict_i = 1 in cycle 10 → cdb_v_o = 0 from cycle 11, fu_ready_o all 1 in cycle 11, no stale result emerges afterwards.
- Age mode (EXE_WB_AGE_PRIO_EN): rob_head_i = 14, ROB_ENTRY = 16, heads with tags FU0 = 3, FU1 = 15, FU3 = 0 → port 0 gets tag 15 and port 1 gets tag 0.
- Async reset asserted mid-cycle with queues non-empty → all outputs 0 immediately; after release the first push emerges 2 cycles later.

Source files
------------

// File: rtl/exe_wb_scheduler_pkg.sv
// exe_wb_scheduler_pkg: shared constants, queue entry type and age helper.
// Optional feature macro: EXE_WB_AGE_PRIO_EN (age-priority scheduling).
package exe_wb_scheduler_pkg;

    localparam int NUM_FU       = 6;
    localparam int NUM_CDB      = 2;
    localparam int WB_Q_DEPTH   = 4;
    localparam int ROB_ENTRY    = 16;
    localparam int ROB_TAG_W    = $clog2(ROB_ENTRY);
    localparam int ROB_WB_WIDTH = 16;
    localparam int REG_WB_WIDTH = 12;
    localparam int CDB_WIDTH    = 8;

    // rob_dest is the top ROB_TAG_W bits of the ROB payload
    typedef struct packed {
        logic [ROB_WB_WIDTH-1:0] rob_wb;
        logic [REG_WB_WIDTH-1:0] reg_wb;
    } wb_entry_t;

    // Distance of a ROB tag from the ROB head; ROB_ENTRY is a power of two
    function automatic logic [ROB_TAG_W-1:0] rob_age(
        input logic [ROB_TAG_W-1:0] tag,
        input logic [ROB_TAG_W-1:0] head
    );
        return tag - head;
    endfunction

endpackage

// File: rtl/exe_wb_scheduler_if.sv
// exe_wb_scheduler_if: FU result inputs, per-FU ready and writeback ports.
// Optional feature macro: EXE_WB_AGE_PRIO_EN (no signals added here).
interface exe_wb_scheduler_if #(
    parameter int NUM_FU_P  = exe_wb_scheduler_pkg::NUM_FU,
    parameter int NUM_CDB_P = exe_wb_scheduler_pkg::NUM_CDB
);
    import exe_wb_scheduler_pkg::*;

    logic [NUM_FU_P-1:0]                    fu_v_i;
    logic [NUM_FU_P-1:0][ROB_WB_WIDTH-1:0]  fu_rob_i;
    logic [NUM_FU_P-1:0][REG_WB_WIDTH-1:0]  fu_reg_i;
    logic [NUM_FU_P-1:0]                    fu_ready_o;
    logic [NUM_CDB_P-1:0]                   cdb_v_o;
    logic [NUM_CDB_P-1:0][CDB_WIDTH-1:0]    cdb_o;
    logic [NUM_CDB_P-1:0][ROB_WB_WIDTH-1:0] exe_rob_o;
    logic [NUM_CDB_P-1:0][REG_WB_WIDTH-1:0] exe_reg_o;

    modport master (
        output fu_v_i, fu_rob_i, fu_reg_i,
        input  fu_ready_o, cdb_v_o, cdb_o, exe_rob_o, exe_reg_o
    );

    modport slave (
        input  fu_v_i, fu_rob_i, fu_reg_i,
        output fu_ready_o, cdb_v_o, cdb_o, exe_rob_o, exe_reg_o
    );

endinterface

// File: rtl/exe_wb_scheduler_fifo.sv
// wb_result_fifo: single-FU writeback queue with push, pop, flush and count.
// Optional feature macro: EXE_WB_AGE_PRIO_EN (not used in this file).
module wb_result_fifo
    import exe_wb_scheduler_pkg::*;
#(
    parameter int DEPTH_P = WB_Q_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  wb_entry_t              wdata_i,
    output wb_entry_t              rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH_P):0] count_o
);
    localparam int PTR_W = $clog2(DEPTH_P);

    wb_entry_t        mem_q [DEPTH_P];
    wb_entry_t        mem_d [DEPTH_P];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH_P));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointer, count and storage update; flush discards everything
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Queue state registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH_P; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/exe_wb_scheduler.sv
// exe_wb_scheduler: per-FU result queues scheduled onto NUM_CDB_P wb ports.
// Optional feature macro: EXE_WB_AGE_PRIO_EN (oldest-first instead of RR).
module exe_wb_scheduler
    import exe_wb_scheduler_pkg::*;
#(
    parameter int NUM_FU_P  = NUM_FU,
    parameter int NUM_CDB_P = NUM_CDB,
    parameter int Q_DEPTH_P = WB_Q_DEPTH
) (
    input  logic clk_i,
    input  logic reset_i,
    exe_wb_scheduler_if.slave wb,
    input  logic mispredict_i
`ifdef EXE_WB_AGE_PRIO_EN
    ,
    input  logic [ROB_TAG_W-1:0] rob_head_i
`endif
);
    localparam int FU_W  = (NUM_FU_P > 1) ? $clog2(NUM_FU_P) : 1;
    localparam int CNT_W = $clog2(Q_DEPTH_P) + 1;

    wb_entry_t            head [NUM_FU_P];
    logic [CNT_W-1:0]     count [NUM_FU_P];
    logic [NUM_FU_P-1:0]  empty, full, push, grant, ready;
    logic [NUM_CDB_P-1:0] sel_v, out_v_q, out_v_d;
    logic [FU_W-1:0]      sel_idx [NUM_CDB_P];
    wb_entry_t            out_q [NUM_CDB_P];
    wb_entry_t            out_d [NUM_CDB_P];

    for (genvar g = 0; g < NUM_FU_P; g++) begin : g_fu
        wb_entry_t wdata;
        assign wdata    = {wb.fu_rob_i[g], wb.fu_reg_i[g]};
        assign ready[g] = (count[g] < CNT_W'(Q_DEPTH_P));
        assign push[g]  = wb.fu_v_i[g] & ready[g] & ~mispredict_i;

        wb_result_fifo #(
            .DEPTH_P (Q_DEPTH_P)
        ) u_fifo (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .flush_i (mispredict_i),
            .push_i  (push[g]),
            .pop_i   (grant[g]),
            .wdata_i (wdata),
            .rdata_o (head[g]),
            .full_o  (full[g]),
            .empty_o (empty[g]),
            .count_o (count[g])
        );
    end

`ifndef EXE_WB_AGE_PRIO_EN
    localparam int PK_W = (NUM_CDB_P > 1) ? $clog2(NUM_CDB_P) : 1;

    logic [FU_W-1:0] rr_ptr_q, rr_ptr_d;

    // Round-robin: first NUM_CDB_P non-empty queues scanning from rr_ptr_q
    always_comb begin
        int              picks;
        int              idx;
        logic [FU_W-1:0] fu;
        logic [PK_W-1:0] pk;
        picks    = 0;
        idx      = 0;
        fu       = '0;
        pk       = '0;
        grant    = '0;
        sel_v    = '0;
        rr_ptr_d = rr_ptr_q;
        for (int k = 0; k < NUM_CDB_P; k++) begin
            sel_idx[k] = '0;
        end
        for (int off = 0; off < NUM_FU_P; off++) begin
            idx = int'(rr_ptr_q) + off;
            if (idx >= NUM_FU_P) begin
                idx = idx - NUM_FU_P;
            end
            fu = FU_W'(idx);
            pk = PK_W'(picks);
            if (!empty[fu] && picks < NUM_CDB_P) begin
                grant[fu]   = 1'b1;
                sel_v[pk]   = 1'b1;
                sel_idx[pk] = fu;
                picks       = picks + 1;
                rr_ptr_d    = (idx == NUM_FU_P - 1) ? '0 : FU_W'(idx + 1);
            end
        end
        if (mispredict_i) begin
            grant    = '0;
            sel_v    = '0;
            rr_ptr_d = '0;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    logic [ROB_TAG_W-1:0] age [NUM_FU_P];

    // Distance of each queue head's rob_dest from the ROB head
    always_comb begin
        for (int i = 0; i < NUM_FU_P; i++) begin
            age[i] = rob_age(head[i].rob_wb[ROB_WB_WIDTH-1 -: ROB_TAG_W],
                             rob_head_i);
        end
    end

    // Oldest heads first onto the lowest ports, ties to the lower FU
    always_comb begin
        logic                 best_v;
        logic [FU_W-1:0]      best_idx;
        logic [ROB_TAG_W-1:0] best_age;
        best_v   = 1'b0;
        best_idx = '0;
        best_age = '0;
        grant    = '0;
        sel_v    = '0;
        for (int k = 0; k < NUM_CDB_P; k++) begin
            sel_idx[k] = '0;
        end
        for (int k = 0; k < NUM_CDB_P; k++) begin
            best_v   = 1'b0;
            best_idx = '0;
            best_age = '0;
            for (int i = 0; i < NUM_FU_P; i++) begin
                if (!empty[i] && !grant[i] &&
                    (!best_v || age[i] < best_age)) begin
                    best_v   = 1'b1;
                    best_idx = FU_W'(i);
                    best_age = age[i];
                end
            end
            if (best_v) begin
                grant[best_idx] = 1'b1;
                sel_v[k]        = 1'b1;
                sel_idx[k]      = best_idx;
            end
        end
        if (mispredict_i) begin
            grant = '0;
            sel_v = '0;
        end
    end
`endif

    // Granted heads load the port registers; idle ports load zero
    always_comb begin
        out_v_d = sel_v;
        for (int k = 0; k < NUM_CDB_P; k++) begin
            out_d[k] = sel_v[k] ? head[sel_idx[k]] : '0;
        end
    end

    // Writeback port registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            out_v_q <= '0;
            for (int k = 0; k < NUM_CDB_P; k++) begin
                out_q[k] <= '0;
            end
        end else begin
            out_v_q <= out_v_d;
            out_q   <= out_d;
        end
    end

    assign wb.fu_ready_o = ready;
    assign wb.cdb_v_o    = out_v_q;

    for (genvar k = 0; k < NUM_CDB_P; k++) begin : g_port
        assign wb.exe_rob_o[k] = out_q[k].rob_wb;
        assign wb.exe_reg_o[k] = out_q[k].reg_wb;
        assign wb.cdb_o[k]     = out_q[k].rob_wb[ROB_WB_WIDTH-1 -: CDB_WIDTH];
    end

    // A result offered to a full queue is dropped by the hardware
    assert property (@(posedge clk_i) disable iff (reset_i)
        (wb.fu_v_i & full) == '0);

endmodule

// File: tb/tb_exe_wb_scheduler.sv
// tb_exe_wb_scheduler: directed vectors plus scoreboarded corner sequences.
// Optional feature macro: EXE_WB_AGE_PRIO_EN selects the age-priority test.
module tb_exe_wb_scheduler;
    import exe_wb_scheduler_pkg::*;

    localparam int NF = 6;
    localparam int NC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mp  = 1'b0;
`ifdef EXE_WB_AGE_PRIO_EN
    logic [ROB_TAG_W-1:0] rob_head = '0;
`endif

    always #5 clk = ~clk;

    exe_wb_scheduler_if #(.NUM_FU_P(NF), .NUM_CDB_P(NC)) wb ();

    exe_wb_scheduler #(
        .NUM_FU_P  (NF),
        .NUM_CDB_P (NC),
        .Q_DEPTH_P (4)
    ) dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .wb           (wb),
        .mispredict_i (mp)
`ifdef EXE_WB_AGE_PRIO_EN
        ,
        .rob_head_i   (rob_head)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int seq   = 0;
    logic [15:0] sbq [NF][$];
    logic saw_low2 = 1'b0;
    int   acc2 = 0;
    int   acc2_at_low = 0;

    typedef struct {
        logic [NF-1:0] fu_v;
        logic [3:0]    tag;
        logic [1:0]    ev;
        logic [3:0]    et0, ef0, et1, ef1;
    } vec_t;

    function automatic logic [15:0] mk_rob(input logic [3:0] t,
                                           input logic [3:0] f,
                                           input logic [7:0] s);
        return {t, f, s};
    endfunction

    function automatic logic [11:0] mk_reg(input logic [3:0] f,
                                           input logic [7:0] s);
        return {s, f};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s", name);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_port(input string nm, input int k, input logic ev,
                            input logic [3:0] t, input logic [3:0] f,
                            input logic [7:0] s);
        check({nm, "_v"}, 32'(wb.cdb_v_o[k]), 32'(ev));
        if (ev) begin
            check({nm, "_rob"}, 32'(wb.exe_rob_o[k]), 32'(mk_rob(t, f, s)));
            check({nm, "_reg"}, 32'(wb.exe_reg_o[k]), 32'(mk_reg(f, s)));
            check({nm, "_cdb"}, 32'(wb.cdb_o[k]), 32'({t, f}));
        end else begin
            check({nm, "_rob0"}, 32'(wb.exe_rob_o[k]), 32'h0);
            check({nm, "_reg0"}, 32'(wb.exe_reg_o[k]), 32'h0);
            check({nm, "_cdb0"}, 32'(wb.cdb_o[k]), 32'h0);
        end
    endtask

    task automatic drive(input logic [NF-1:0] m, input logic [3:0] t,
                         input logic [7:0] s);
        for (int i = 0; i < NF; i++) begin
            wb.fu_rob_i[i] = mk_rob(t, 4'(i), s);
            wb.fu_reg_i[i] = mk_reg(4'(i), s);
        end
        wb.fu_v_i = m;
    endtask

    // One scoreboarded cycle: check outputs, offer results where ready
    task automatic sb_cycle(input logic [NF-1:0] want, input logic flush);
        logic [NF-1:0] m;
        logic [3:0]    f;
        logic [15:0]   e;
        for (int k = 0; k < NC; k++) begin
            if (wb.cdb_v_o[k]) begin
                f = wb.exe_rob_o[k][11:8];
                if (f < NF && sbq[f].size() > 0) begin
                    e = sbq[f].pop_front();
                    check("sb_rob", 32'(wb.exe_rob_o[k]), 32'(e));
                    check("sb_reg", 32'(wb.exe_reg_o[k]),
                          32'(mk_reg(f, e[7:0])));
                    check("sb_cdb", 32'(wb.cdb_o[k]), 32'(e[15:8]));
                end else begin
                    fail("sb_stray");
                end
            end
        end
        if (&wb.cdb_v_o) begin
            check("sb_one_per_fu",
                  32'(wb.exe_rob_o[0][11:8] != wb.exe_rob_o[1][11:8]), 32'h1);
        end
        if (!wb.fu_ready_o[2] && !saw_low2) begin
            saw_low2    = 1'b1;
            acc2_at_low = acc2;
        end
        m = '0;
        for (int i = 0; i < NF; i++) begin
            e = mk_rob(seq[3:0], 4'(i), seq[7:0]);
            wb.fu_rob_i[i] = e;
            wb.fu_reg_i[i] = mk_reg(4'(i), seq[7:0]);
            if (want[i] && wb.fu_ready_o[i]) begin
                m[i] = 1'b1;
                if (!flush) begin
                    sbq[i].push_back(e);
                    if (i == 2) acc2++;
                end
            end
            seq++;
        end
        wb.fu_v_i = m;
        mp = flush;
        if (flush) begin
            for (int i = 0; i < NF; i++) sbq[i].delete();
        end
        tick();
        mp = 1'b0;
        wb.fu_v_i = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vec [13];

        wb.fu_v_i   = '0;
        wb.fu_rob_i = '0;
        wb.fu_reg_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_v", 32'(wb.cdb_v_o), 32'h0);
        check("rst_rob", 32'(wb.exe_rob_o), 32'h0);
        check("rst_reg", 32'(wb.exe_reg_o), 32'h0);
        check("rst_cdb", 32'(wb.cdb_o), 32'h0);
        check("rst_ready", 32'(wb.fu_ready_o), 32'h3f);

`ifndef EXE_WB_AGE_PRIO_EN
        vec[0]  = '{6'h3f, 4'h2, 2'b00, 0, 0, 0, 0};
        vec[1]  = '{6'h00, 4'h0, 2'b11, 2, 0, 2, 1};
        vec[2]  = '{6'h00, 4'h0, 2'b11, 2, 2, 2, 3};
        vec[3]  = '{6'h00, 4'h0, 2'b11, 2, 4, 2, 5};
        vec[4]  = '{6'h01, 4'h5, 2'b00, 0, 0, 0, 0};
        vec[5]  = '{6'h00, 4'h0, 2'b01, 5, 0, 0, 0};
        vec[6]  = '{6'h09, 4'h7, 2'b00, 0, 0, 0, 0};
        vec[7]  = '{6'h00, 4'h0, 2'b11, 7, 3, 7, 0};
        vec[8]  = '{6'h00, 4'h0, 2'b00, 0, 0, 0, 0};
        vec[9]  = '{6'h02, 4'h9, 2'b00, 0, 0, 0, 0};
        vec[10] = '{6'h02, 4'ha, 2'b01, 9, 1, 0, 0};
        vec[11] = '{6'h00, 4'h0, 2'b01, 10, 1, 0, 0};
        vec[12] = '{6'h00, 4'h0, 2'b00, 0, 0, 0, 0};
        for (int r = 0; r < 13; r++) begin
            drive(vec[r].fu_v, vec[r].tag, 8'ha5);
            tick();
            chk_port("vec_p0", 0, vec[r].ev[0], vec[r].et0, vec[r].ef0, 8'ha5);
            chk_port("vec_p1", 1, vec[r].ev[1], vec[r].et1, vec[r].ef1, 8'ha5);
            check("vec_ready", 32'(wb.fu_ready_o), 32'h3f);
        end
        wb.fu_v_i = '0;
`else
        rob_head = 4'd14;
        wb.fu_v_i = '0;
        wb.fu_rob_i[0] = mk_rob(4'd3, 4'd0, 8'h10);
        wb.fu_reg_i[0] = mk_reg(4'd0, 8'h10);
        wb.fu_rob_i[1] = mk_rob(4'd15, 4'd1, 8'h11);
        wb.fu_reg_i[1] = mk_reg(4'd1, 8'h11);
        wb.fu_rob_i[3] = mk_rob(4'd0, 4'd3, 8'h13);
        wb.fu_reg_i[3] = mk_reg(4'd3, 8'h13);
        wb.fu_v_i = 6'b001011;
        tick();
        wb.fu_v_i = '0;
        check("age_lat_v", 32'(wb.cdb_v_o), 32'h0);
        tick();
        chk_port("age_p0", 0, 1'b1, 4'd15, 4'd1, 8'h11);
        chk_port("age_p1", 1, 1'b1, 4'd0, 4'd3, 8'h13);
        tick();
        chk_port("age_rest", 0, 1'b1, 4'd3, 4'd0, 8'h10);
        rob_head = '0;
        tick();
`endif

        // All FUs stream; FU2 must back up, nothing lost, order kept
        for (int c = 0; c < 20; c++) sb_cycle(6'h3f, 1'b0);
        for (int c = 0; c < 20; c++) sb_cycle(6'h00, 1'b0);
        check("bp_ready_low", 32'(saw_low2), 32'h1);
        check("bp_fill", 32'(acc2_at_low >= 4), 32'h1);
        for (int i = 0; i < NF; i++) begin
            check("bp_drained", 32'(sbq[i].size()), 32'h0);
        end

        // Flush with queues loaded, then new results after the flush
        for (int c = 0; c < 6; c++) sb_cycle(6'h3f, 1'b0);
        sb_cycle(6'h3f, 1'b1);
        check("flush_v", 32'(wb.cdb_v_o), 32'h0);
        check("flush_rob", 32'(wb.exe_rob_o), 32'h0);
        check("flush_ready", 32'(wb.fu_ready_o), 32'h3f);
        drive(6'b100001, 4'hb, 8'h3c);
        tick();
        wb.fu_v_i = '0;
        check("flush_m2_v", 32'(wb.cdb_v_o), 32'h0);
        tick();
        chk_port("flush_m3_p0", 0, 1'b1, 4'hb, 4'd0, 8'h3c);
        chk_port("flush_m3_p1", 1, 1'b1, 4'hb, 4'd5, 8'h3c);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("flush_no_stale", 32'(wb.cdb_v_o), 32'h0);
        end

        // Asynchronous reset in mid-cycle with queues non-empty
        drive(6'h3f, 4'h6, 8'h11);
        tick();
        drive(6'h3f, 4'h7, 8'h12);
        tick();
        wb.fu_v_i = '0;
        tick();
        check("pre_rst_v", 32'(wb.cdb_v_o), 32'h3);
        #3;
        rst = 1'b1;
        #1;
        check("arst_v", 32'(wb.cdb_v_o), 32'h0);
        check("arst_rob", 32'(wb.exe_rob_o), 32'h0);
        check("arst_reg", 32'(wb.exe_reg_o), 32'h0);
        check("arst_ready", 32'(wb.fu_ready_o), 32'h3f);
        #2;
        rst = 1'b0;
        drive(6'b001000, 4'hc, 8'h77);
        tick();
        wb.fu_v_i = '0;
        check("arst_lat_v", 32'(wb.cdb_v_o), 32'h0);
        tick();
        chk_port("arst_p0", 0, 1'b1, 4'hc, 4'd3, 8'h77);
        chk_port("arst_p1", 1, 1'b0, 4'h0, 4'h0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
